// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Brief    : Two-requester round-robin arbiter for a shared byte-level I2C
//            master. It grants the bus, routes commands and responses, and
//            closes an abandoned open transaction with a forced STOP.
// Revision : 1.0  initial release
// ============================================================================
module i2c_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 270000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_i,
    output logic [1:0]  gnt_o,
    input  logic [1:0]  rq_cmd_valid_i,
    input  logic [25:0] rq_cmd_i,
    output logic [1:0]  rq_cmd_ready_o,
    output logic        m_cmd_valid_o,
    output logic [12:0] m_cmd_o,
    input  logic        m_cmd_ready_i,
    input  logic        m_rsp_valid_i,
    input  logic [7:0]  m_rsp_data_i,
    input  logic        m_rsp_nack_i,
    output logic [1:0]  rq_rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_nack_o,
    output logic        busy_o,
    output logic        timeout_o
);

    // Counter is wide enough to hold TIMEOUT_CYCLES itself.
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    // Terminal count: the cycle on which the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0]  CNT_TC   = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    // Stop-only command used to close a bus left open by a departing owner.
    localparam logic [12:0]       STOP_CMD = 13'h0800;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_WAIT_RSP   = 3'd2,
        ST_FORCE_STOP = 3'd3,
        ST_WAIT_STOP  = 3'd4
    } state_e;

    state_e           state_q;
    logic             owner_q;      // index of the current/last grantee
    logic             ptr_q;        // round-robin priority pointer
    logic             bus_open_q;   // START issued without a matching STOP yet
    logic             cmd_stop_q;   // outstanding command carries STOP
    logic [CNT_W-1:0] cnt_q;        // idle cycles of the current grantee
    logic [1:0]       inelig_q;     // revoked requesters awaiting a req_i low

    logic [12:0]      own_cmd;
    logic [1:0]       elig;
    logic             grant_idx;
    logic             cmd_hs;
    logic             own_req;
    logic             tc;
    logic             bus_open_d;

    assign own_cmd   = owner_q ? rq_cmd_i[25:13] : rq_cmd_i[12:0];
    assign elig      = req_i & ~inelig_q;
    assign grant_idx = elig[ptr_q] ? ptr_q : ~ptr_q;
    assign cmd_hs    = (state_q == ST_GRANT) && rq_cmd_valid_i[owner_q] && m_cmd_ready_i;
    assign own_req   = req_i[owner_q];
    assign tc        = (cnt_q == CNT_TC);
    // bus_open as it will stand once the outstanding response has been applied.
    assign bus_open_d = bus_open_q & ~cmd_stop_q;
    assign busy_o    = (state_q != ST_IDLE);

    // Command channel mux: owner pass-through in GRANT, stop-only in FORCE_STOP.
    always_comb begin
        m_cmd_valid_o  = 1'b0;
        m_cmd_o        = 13'h0000;
        rq_cmd_ready_o = 2'b00;
        case (state_q)
            ST_GRANT: begin
                m_cmd_valid_o           = rq_cmd_valid_i[owner_q];
                m_cmd_o                 = own_cmd;
                rq_cmd_ready_o[owner_q] = m_cmd_ready_i;
            end
            ST_FORCE_STOP: begin
                m_cmd_valid_o = 1'b1;
                m_cmd_o       = STOP_CMD;
            end
            default: ;
        endcase
    end

    // Arbitration FSM with registered grant, response routing and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            ptr_q          <= 1'b0;
            bus_open_q     <= 1'b0;
            cmd_stop_q     <= 1'b0;
            cnt_q          <= '0;
            inelig_q       <= 2'b00;
            gnt_o          <= 2'b00;
            rq_rsp_valid_o <= 2'b00;
            rsp_data_o     <= 8'h00;
            rsp_nack_o     <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            rq_rsp_valid_o <= 2'b00;
            timeout_o      <= 1'b0;

            // A revoked requester regains eligibility once seen low.
            for (int n = 0; n < 2; n++) begin
                if (!req_i[n]) begin
                    inelig_q[n] <= 1'b0;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (|elig) begin
                        owner_q <= grant_idx;
                        ptr_q   <= ~grant_idx;
                        gnt_o   <= 2'b01 << grant_idx;
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    if (cmd_hs) begin
                        // A handshake beats release and terminal count.
                        cnt_q      <= '0;
                        cmd_stop_q <= own_cmd[11];
                        if (own_cmd[12]) begin
                            bus_open_q <= 1'b1;
                        end
                        state_q <= ST_WAIT_RSP;
                    end else if (!own_req || tc) begin
                        gnt_o   <= 2'b00;
                        state_q <= bus_open_q ? ST_FORCE_STOP : ST_IDLE;
                        if (own_req) begin
                            timeout_o         <= 1'b1;
                            inelig_q[owner_q] <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_WAIT_RSP: begin
                    if (m_rsp_valid_i) begin
                        rq_rsp_valid_o[owner_q] <= 1'b1;
                        rsp_data_o              <= m_rsp_data_i;
                        rsp_nack_o              <= m_rsp_nack_i;
                        bus_open_q              <= bus_open_d;
                        // A release requested during the transfer applies now.
                        if (!own_req) begin
                            gnt_o   <= 2'b00;
                            state_q <= bus_open_d ? ST_FORCE_STOP : ST_IDLE;
                        end else begin
                            state_q <= ST_GRANT;
                        end
                    end
                end

                ST_FORCE_STOP: begin
                    if (m_cmd_ready_i) begin
                        state_q <= ST_WAIT_STOP;
                    end
                end

                ST_WAIT_STOP: begin
                    // The stop response is swallowed; nobody owns it.
                    if (m_rsp_valid_i) begin
                        bus_open_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_arbiter
// Brief    : Directed self-checking bench for i2c_bus_arbiter (TIMEOUT 16).
// Revision : 1.0  initial release
// ============================================================================
module tb_i2c_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  rq_cmd_valid;
    logic [25:0] rq_cmd;
    logic [1:0]  rq_cmd_ready;
    logic        m_cmd_valid;
    logic [12:0] m_cmd;
    logic        m_cmd_ready;
    logic        m_rsp_valid;
    logic [7:0]  m_rsp_data;
    logic        m_rsp_nack;
    logic [1:0]  rq_rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_nack;
    logic        busy;
    logic        timeout;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    i2c_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req),
        .gnt_o          (gnt),
        .rq_cmd_valid_i (rq_cmd_valid),
        .rq_cmd_i       (rq_cmd),
        .rq_cmd_ready_o (rq_cmd_ready),
        .m_cmd_valid_o  (m_cmd_valid),
        .m_cmd_o        (m_cmd),
        .m_cmd_ready_i  (m_cmd_ready),
        .m_rsp_valid_i  (m_rsp_valid),
        .m_rsp_data_i   (m_rsp_data),
        .m_rsp_nack_i   (m_rsp_nack),
        .rq_rsp_valid_o (rq_rsp_valid),
        .rsp_data_o     (rsp_data),
        .rsp_nack_o     (rsp_nack),
        .busy_o         (busy),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from requester n, hold req at req_during for the
    // wait, answer with data d, and check the routed response.
    task automatic do_cmd(input int n, input logic [12:0] cmd, input logic [7:0] d,
                          input logic [1:0] req_during, input string tag);
        rq_cmd_valid = 2'b01 << n;
        rq_cmd       = (n == 1) ? {cmd, 13'h0000} : {13'h0000, cmd};
        m_cmd_ready  = 1'b1;
        #1;
        chk({tag, "_mcmd"}, {3'b000, m_cmd}, {3'b000, cmd});
        chk({tag, "_rdy"}, {14'h0, rq_cmd_ready}, {14'h0, 2'b01 << n});
        tick();
        rq_cmd_valid = 2'b00;
        m_cmd_ready  = 1'b0;
        req          = req_during;
        m_rsp_valid  = 1'b1;
        m_rsp_data   = d;
        tick();
        m_rsp_valid  = 1'b0;
        chk({tag, "_rspv"}, {14'h0, rq_rsp_valid}, {14'h0, 2'b01 << n});
        chk({tag, "_rspd"}, {8'h00, rsp_data}, {8'h00, d});
    endtask

    initial begin
        int cnt;
        bit seen;

        rst_n = 1'b0; req = 2'b00; rq_cmd_valid = 2'b00; rq_cmd = '0;
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = 8'h00; m_rsp_nack = 1'b0;
        tick(); tick();
        chk("rst_gnt",  {14'h0, gnt}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_mcmd", {2'b00, m_cmd_valid, m_cmd}, 16'h0);
        rst_n = 1'b1;
        tick();

        // Single requester: two commands, stop closes the bus, clean release.
        req = 2'b01; #1;
        chk("t1_gnt_pre", {14'h0, gnt}, 16'h0);
        tick();
        chk("t1_gnt", {14'h0, gnt}, 16'h1);
        chk("t1_busy", {15'h0, busy}, 16'h1);
        do_cmd(0, 13'h14A0, 8'h00, 2'b01, "t1a");
        do_cmd(0, 13'h0F00, 8'h5A, 2'b01, "t1b");
        req = 2'b00;
        tick();
        chk("t1_rel_gnt", {14'h0, gnt}, 16'h0);
        chk("t1_rel_busy", {15'h0, busy}, 16'h0);
        tick();
        chk("t1_nostop", {15'h0, m_cmd_valid}, 16'h0);

        // Round robin from reset: 01, 10, 01 with one idle cycle between.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 2'b11;
        tick();
        chk("t2_g0", {14'h0, gnt}, 16'h1);
        do_cmd(0, 13'h0400, 8'h11, 2'b10, "t2a");
        chk("t2_gap1", {14'h0, gnt}, 16'h0);
        tick();
        chk("t2_g1", {14'h0, gnt}, 16'h2);
        req = 2'b11;
        do_cmd(1, 13'h0400, 8'h22, 2'b11, "t2b");
        req = 2'b01;
        tick();
        chk("t2_gap2", {14'h0, gnt}, 16'h0);
        tick();
        chk("t2_g2", {14'h0, gnt}, 16'h1);
        req = 2'b00;
        tick();

        // Start-only command then drop: forced stop, response swallowed.
        req = 2'b10;
        tick();
        chk("t3_gnt", {14'h0, gnt}, 16'h2);
        do_cmd(1, 13'h1000, 8'h3C, 2'b10, "t3");
        req = 2'b00;
        tick();
        chk("t3_gnt_off", {14'h0, gnt}, 16'h0);
        chk("t3_fs_cmd", {2'b00, m_cmd_valid, m_cmd}, 16'h2800);
        tick();
        chk("t3_fs_hold", {2'b00, m_cmd_valid, m_cmd}, 16'h2800);
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0; #1;
        chk("t3_ws_valid", {15'h0, m_cmd_valid}, 16'h0);
        chk("t3_ws_busy", {15'h0, busy}, 16'h1);
        m_rsp_valid = 1'b1; m_rsp_data = 8'h77;
        tick();
        m_rsp_valid = 1'b0;
        chk("t3_no_rspv", {14'h0, rq_rsp_valid}, 16'h0);
        chk("t3_data_kept", {8'h00, rsp_data}, 16'h003C);
        tick();
        chk("t3_idle", {15'h0, busy}, 16'h0);

        // Timeout after a start: pulse, forced stop, no regrant until toggle.
        req = 2'b01;
        tick();
        chk("t4_gnt", {14'h0, gnt}, 16'h1);
        do_cmd(0, 13'h1400, 8'h00, 2'b01, "t4");
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            cnt++;
            if (timeout === 1'b1) seen = 1'b1;
        end
        chk("t4_to_delay", cnt[15:0], 16'd15);
        chk("t4_gnt_off", {14'h0, gnt}, 16'h0);
        chk("t4_fs_cmd", {2'b00, m_cmd_valid, m_cmd}, 16'h2800);
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        chk("t4_to_pulse", {15'h0, timeout}, 16'h0);
        m_rsp_valid = 1'b1;
        tick();
        m_rsp_valid = 1'b0;
        tick(); tick(); tick();
        chk("t4_no_regrant", {14'h0, gnt}, 16'h0);
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        chk("t4_regrant", {14'h0, gnt}, 16'h1);

        // Handshake exactly on the terminal-count cycle wins over timeout.
        repeat (14) tick();
        chk("t5_no_to_yet", {15'h0, timeout}, 16'h0);
        rq_cmd_valid = 2'b01; rq_cmd = {13'h0000, 13'h1400}; m_cmd_ready = 1'b1; #1;
        chk("t5_valid", {15'h0, m_cmd_valid}, 16'h1);
        tick();
        m_cmd_ready = 1'b0; #1;
        chk("t5_no_to", {15'h0, timeout}, 16'h0);
        chk("t5_in_wait", {15'h0, m_cmd_valid}, 16'h0);
        chk("t5_gnt", {14'h0, gnt}, 16'h1);
        rq_cmd_valid = 2'b00;
        tick();
        chk("t5_no_to2", {15'h0, timeout}, 16'h0);
        m_rsp_valid = 1'b1; m_rsp_data = 8'h99;
        tick();
        m_rsp_valid = 1'b0;
        chk("t5_rspv", {14'h0, rq_rsp_valid}, 16'h1);

        // Asynchronous reset in WAIT_RSP; late response ignored.
        rq_cmd_valid = 2'b01; rq_cmd = {13'h0000, 13'h0400}; m_cmd_ready = 1'b1;
        tick();
        rq_cmd_valid = 2'b00; m_cmd_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_gnt", {14'h0, gnt}, 16'h0);
        chk("t6_busy", {15'h0, busy}, 16'h0);
        chk("t6_data", {7'h00, rsp_nack, rsp_data}, 16'h0);
        req = 2'b00;
        tick();
        rst_n = 1'b1;
        m_rsp_valid = 1'b1; m_rsp_data = 8'hAB;
        tick(); tick();
        m_rsp_valid = 1'b0;
        chk("t6_late_v", {14'h0, rq_rsp_valid}, 16'h0);
        chk("t6_late_d", {8'h00, rsp_data}, 16'h0);
        chk("t6_idle", {15'h0, busy}, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
